// File: rtl/periph_arb_pkg.sv
// rtl/periph_arb_pkg.sv - shared state, grant and timeout constants for periph_wb_arbiter
package periph_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/periph_arb_timeout.sv
// rtl/periph_arb_timeout.sv - stall counter that flags a stuck slave strobe
// tmo is a one-cycle pulse; an ack in the same cycle always suppresses it.
module periph_arb_timeout
  import periph_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic stb,
  input  logic ack,
  output logic tmo
);

  localparam logic [CNT_W-1:0] LIMIT = TIMEOUT_CYCLES[CNT_W-1:0];

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter value equals the number of cycles the current strobe has waited.
  always_comb begin
    tmo   = active & stb & ~ack & (cnt_q == LIMIT);
    cnt_d = cnt_q + 1'b1;
    if (!active || !stb || ack || tmo) begin
      cnt_d = '0;
    end
  end

endmodule

// File: rtl/periph_wb_arbiter.sv
// rtl/periph_wb_arbiter.sv - two-master classic Wishbone arbiter with stall timeout
// Define PERIPH_ARB_RR_EN for round-robin contention; default is fixed M0 priority.
module periph_wb_arbiter
  import periph_arb_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  output logic [1:0]      gnt_o,
  output logic            tmo_irq_o
);

  arb_state_e state_q, state_d;

  logic            own0, own1, own_any;
  logic            own_cyc, own_stb, own_we;
  logic [DW/8-1:0] own_sel;
  logic [AW-1:0]   own_adr;
  logic [DW-1:0]   own_dat;
  logic            m0_first;
  logic            tmo;

`ifdef PERIPH_ARB_RR_EN
  logic last_q, last_d;

  // last_q=1 means M1 was served last, so M0 wins the next contention.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_q == ST_IDLE && state_d != ST_IDLE) begin
      last_d = (state_d == ST_OWN1);
    end
  end

  assign m0_first = last_q;
`else
  assign m0_first = 1'b1;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ownership lasts the whole cyc window; release always passes through IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = m0_first ? ST_OWN0 : ST_OWN1;
        end else if (m0_cyc_i) begin
          state_d = ST_OWN0;
        end else if (m1_cyc_i) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0: if (!m0_cyc_i) state_d = ST_IDLE;
      ST_OWN1: if (!m1_cyc_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    own0    = (state_q == ST_OWN0);
    own1    = (state_q == ST_OWN1);
    own_any = own0 | own1;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_sel = '0;
    own_adr = '0;
    own_dat = '0;
    if (own0) begin
      own_cyc = m0_cyc_i;
      own_stb = m0_cyc_i & m0_stb_i;
      own_we  = m0_we_i;
      own_sel = m0_sel_i;
      own_adr = m0_adr_i;
      own_dat = m0_dat_i;
    end else if (own1) begin
      own_cyc = m1_cyc_i;
      own_stb = m1_cyc_i & m1_stb_i;
      own_we  = m1_we_i;
      own_sel = m1_sel_i;
      own_adr = m1_adr_i;
      own_dat = m1_dat_i;
    end
  end

  periph_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .active(own_any),
    .stb   (own_stb),
    .ack   (s_ack_i),
    .tmo   (tmo)
  );

  // Strobe is withdrawn in the timeout cycle so the slave sees the beat end with the error.
  always_comb begin
    gnt_o     = own0 ? GNT_M0 : (own1 ? GNT_M1 : GNT_NONE);
    s_cyc_o   = own_cyc;
    s_stb_o   = own_stb & ~tmo;
    s_we_o    = own_we;
    s_sel_o   = own_sel;
    s_adr_o   = own_adr;
    s_dat_o   = own_dat;
    m0_ack_o  = own0 & own_cyc & s_ack_i;
    m1_ack_o  = own1 & own_cyc & s_ack_i;
    m0_err_o  = own0 & tmo;
    m1_err_o  = own1 & tmo;
    m0_dat_o  = own0 ? s_dat_i : '0;
    m1_dat_o  = own1 ? s_dat_i : '0;
    tmo_irq_o = tmo;
  end

endmodule

// File: tb/tb_periph_wb_arbiter.sv
// tb/tb_periph_wb_arbiter.sv - randomized bench for periph_wb_arbiter against a cycle-number reference model
module tb_periph_wb_arbiter;

  localparam int TMO = 8;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni;
  logic        mc [2];
  logic        ms [2];
  logic        mw [2];
  logic [3:0]  msel [2];
  logic [31:0] madr [2];
  logic [31:0] mdat [2];
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, tmo_irq_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  gnt_o;

  always #5 wb_clk_i = ~wb_clk_i;

  periph_wb_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .m0_cyc_i(mc[0]), .m0_stb_i(ms[0]), .m0_we_i(mw[0]), .m0_sel_i(msel[0]),
    .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(mc[1]), .m1_stb_i(ms[1]), .m1_we_i(mw[1]), .m1_sel_i(msel[1]),
    .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o), .tmo_irq_o(tmo_irq_o)
  );

  int n_cmp, n_bad;
  int cyc_n, owner, wstart, lat, force_lat, beats;
  int n_tmo, n_ack8, n_cont;
  bit last1;
  bit done [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic new_beat(input int i);
    ms[i]   = 1'b1;
    mw[i]   = 1'($urandom_range(0, 1));
    msel[i] = 4'($urandom_range(1, 15));
    madr[i] = $urandom();
    mdat[i] = $urandom();
  endtask

  // One bus cycle: slave response, expected outputs, then ownership bookkeeping.
  // owner: 0 none, 1 M0, 2 M1. wstart: cycle the current strobe began waiting.
  task automatic cycle_check();
    logic        ocyc, ostb, ack, tmo_e, e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_adr, e_dat;
    int          o, el, nxt;
    o = owner;
    ocyc = 1'b0; ostb = 1'b0; e_we = 1'b0; e_sel = '0; e_adr = '0; e_dat = '0;
    if (o != 0) begin
      ocyc  = mc[o-1];
      ostb  = mc[o-1] & ms[o-1];
      e_we  = mw[o-1];
      e_sel = msel[o-1];
      e_adr = madr[o-1];
      e_dat = mdat[o-1];
    end
    if (ostb && wstart < 0) begin
      wstart = cyc_n;
      lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, TMO + 2));
    end
    el    = cyc_n - wstart;
    ack   = ostb && (el == lat);
    tmo_e = ostb && !ack && (el == TMO);
    s_ack_i = ack;
    s_dat_i = $urandom();
    if (o == 0 && mc[0] && mc[1]) n_cont++;
    if (tmo_e) n_tmo++;
    if (ack && el == TMO) n_ack8++;
    #1;
    check_eq("gnt", gnt_o, (o == 1) ? 2'b01 : ((o == 2) ? 2'b10 : 2'b00));
    check_eq("s_cyc", s_cyc_o, ocyc);
    check_eq("s_stb", s_stb_o, ostb && !tmo_e);
    check_eq("s_we", s_we_o, e_we);
    check_eq("s_sel", s_sel_o, e_sel);
    check_eq("s_adr", s_adr_o, e_adr);
    check_eq("s_dat", s_dat_o, e_dat);
    check_eq("m0_ack", m0_ack_o, (o == 1) && ack);
    check_eq("m0_err", m0_err_o, (o == 1) && tmo_e);
    check_eq("m0_dat", m0_dat_o, (o == 1) ? s_dat_i : 32'h0);
    check_eq("m1_ack", m1_ack_o, (o == 2) && ack);
    check_eq("m1_err", m1_err_o, (o == 2) && tmo_e);
    check_eq("m1_dat", m1_dat_o, (o == 2) ? s_dat_i : 32'h0);
    check_eq("tmo_irq", tmo_irq_o, tmo_e);
    done[0] = (o == 1) && (ack || tmo_e);
    done[1] = (o == 2) && (ack || tmo_e);
    if (!ostb || ack || tmo_e) wstart = -1;
    if (o == 0) begin
      nxt = 0;
      if (mc[0] && mc[1]) begin
        nxt = 1;
`ifdef PERIPH_ARB_RR_EN
        if (!last1) nxt = 2;
`endif
      end else if (mc[0]) begin
        nxt = 1;
      end else if (mc[1]) begin
        nxt = 2;
      end
      if (nxt != 0) last1 = (nxt == 2);
      owner = nxt;
    end else if (!mc[o-1]) begin
      owner = 0;
    end
    @(posedge wb_clk_i);
    cyc_n++;
    @(negedge wb_clk_i);
  endtask

  task automatic drive_masters();
    for (int i = 0; i < 2; i++) begin
      if (mc[i]) begin
        if (done[i]) begin
          ms[i] = 1'b0;
          if ($urandom_range(0, 1) == 1) mc[i] = 1'b0;
          else if ($urandom_range(0, 2) == 0) new_beat(i);
        end else if (ms[i]) begin
          if ($urandom_range(0, 40) == 0) begin
            mc[i] = 1'b0;
            ms[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          new_beat(i);
        end else if ($urandom_range(0, 3) == 0) begin
          mc[i] = 1'b0;
        end
      end else if ($urandom_range(0, 5) == 0) begin
        mc[i] = 1'b1;
        new_beat(i);
      end
    end
  endtask

  task automatic run_beat(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic we, input int l);
    bit fin;
    fin = 1'b0;
    force_lat = l;
    mc[i] = 1'b1; ms[i] = 1'b1; mw[i] = we; msel[i] = 4'hF; madr[i] = a; mdat[i] = d;
    for (int k = 0; k < 40 && !fin; k++) begin
      cycle_check();
      if (done[i]) fin = 1'b1;
    end
    check_eq("beat_done", fin, 1'b1);
    ms[i] = 1'b0; mc[i] = 1'b0;
    cycle_check();
    cycle_check();
    force_lat = -1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc_n = 0; owner = 0; wstart = -1; lat = 0; force_lat = -1;
    n_tmo = 0; n_ack8 = 0; n_cont = 0; beats = 0; last1 = 1'b1;
    done[0] = 1'b0; done[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mc[i] = 1'b0; ms[i] = 1'b0; mw[i] = 1'b0; msel[i] = '0; madr[i] = '0; mdat[i] = '0;
    end
    s_ack_i = 1'b0;
    s_dat_i = 32'hDEAD_BEEF;
    wb_rst_ni = 1'b1;
    #1 wb_rst_ni = 1'b0;
    mc[0] = 1'b1; ms[0] = 1'b1; madr[0] = 32'h1234_5678; mdat[0] = 32'h9ABC_DEF0;
    repeat (2) @(negedge wb_clk_i);
    #1;
    check_eq("rst_gnt", gnt_o, 2'b00);
    check_eq("rst_s_cyc", s_cyc_o, 1'b0);
    check_eq("rst_s_stb", s_stb_o, 1'b0);
    check_eq("rst_s_adr", s_adr_o, 32'h0);
    check_eq("rst_s_dat", s_dat_o, 32'h0);
    check_eq("rst_m0_dat", m0_dat_o, 32'h0);
    check_eq("rst_acks_errs", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, tmo_irq_o}, 5'b0);
    mc[0] = 1'b0; ms[0] = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);

    run_beat(0, 32'h3000_0004, 32'hA5A5_1234, 1'b1, 2);
    run_beat(0, 32'h3000_0010, 32'h0, 1'b0, 100);
    run_beat(1, 32'h3000_0020, 32'h1111_2222, 1'b1, TMO);

    force_lat = 1;
    mc[0] = 1'b1; new_beat(0);
    mc[1] = 1'b1; new_beat(1);
    cycle_check();
    check_eq("contend_first", gnt_o, 2'b01);
    for (int k = 0; k < 60 && (mc[0] || mc[1]); k++) begin
      for (int i = 0; i < 2; i++) if (done[i]) begin ms[i] = 1'b0; mc[i] = 1'b0; end
      cycle_check();
    end
    check_eq("contend_drained", mc[0] | mc[1], 1'b0);
    cycle_check();

    mc[1] = 1'b1; new_beat(1); mw[1] = 1'b0;
    cycle_check();
    mc[0] = 1'b1; new_beat(0);
    beats = 0;
    for (int k = 0; k < 60 && mc[0]; k++) begin
      if (done[1]) begin
        beats++;
        if (beats == 1) begin new_beat(1); mw[1] = 1'b1; end
        else begin ms[1] = 1'b0; mc[1] = 1'b0; end
      end
      if (done[0]) begin ms[0] = 1'b0; mc[0] = 1'b0; end
      cycle_check();
    end
    check_eq("rmw_m0_served", mc[0], 1'b0);
    force_lat = -1;
    cycle_check();

    for (int k = 0; k < 4000; k++) begin
      drive_masters();
      cycle_check();
    end
    for (int i = 0; i < 2; i++) begin mc[i] = 1'b0; ms[i] = 1'b0; end
    repeat (3) cycle_check();

    force_lat = 100;
    mc[1] = 1'b1; new_beat(1);
    cycle_check();
    cycle_check();
    check_eq("pre_rst_gnt", gnt_o, 2'b10);
    #2 wb_rst_ni = 1'b0;
    #1;
    check_eq("async_rst_gnt", gnt_o, 2'b00);
    check_eq("async_rst_s_cyc", s_cyc_o, 1'b0);
    check_eq("async_rst_s_stb", s_stb_o, 1'b0);
    mc[1] = 1'b0; ms[1] = 1'b0;
    owner = 0; wstart = -1; last1 = 1'b1; force_lat = -1;
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);
    run_beat(0, 32'h3000_0040, 32'h5555_AAAA, 1'b1, 1);

    check_eq("cov_timeouts", n_tmo > 2, 1'b1);
    check_eq("cov_ack_at_limit", n_ack8 > 0, 1'b1);
    check_eq("cov_contention", n_cont > 2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/periph_wb_arbiter.md
Name: periph_wb_arbiter

Overview:
- Two-master, one-slave Wishbone (classic, 32-bit) arbiter in front of the caravel_peripheral_macro slave port.
- M0 is the Caravel management Wishbone; M1 is an on-chip requester, e.g. a future DMA or SPI sequencer.
- Holds the grant for the whole cyc window, so read-modify-write sequences stay atomic.
- Terminates stalled slave cycles with an error after a programmable timeout.

Parameters:
- AW, 32, address width for all address ports.
- DW, 32, data width; byte-select width is DW/8.
- TIMEOUT_CYCLES, 255, cycles of stb without ack before a forced error termination; legal range 1..65535.
- CNT_W, 16, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- wb_clk_i  in  1  system clock, rising edge.
- wb_rst_ni  in  1  asynchronous active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle, strobe, write enable.
- m0_sel_i  in  DW/8  master 0 byte selects.
- m0_adr_i  in  AW  master 0 address.
- m0_dat_i  in  DW  master 0 write data.
- m0_dat_o  out  DW  master 0 read data.
- m0_ack_o  out  1  master 0 acknowledge.
- m0_err_o  out  1  master 0 error (timeout).
- m1_* (cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, dat_o, ack_o, err_o)  same widths  master 1 equivalents.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle, strobe, write enable.
- s_sel_o  out  DW/8  slave byte selects.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_dat_i  in  DW  slave read data.
- s_ack_i  in  1  slave acknowledge.
- gnt_o  out  2  one-hot current owner; 00 = idle.
- tmo_irq_o  out  1  single-cycle pulse on each timeout.

Behaviour:
- Reset (async assert, sync deassert handled externally): state IDLE, gnt_o=00, all s_* outputs 0, all m*_ack_o/err_o 0, m*_dat_o 0, timeout counter 0, tmo_irq_o 0.
- FSM states: IDLE, OWN0, OWN1.
- IDLE: sample m0_cyc_i and m1_cyc_i. Neither set: stay. One set: go to OWNx. Both set: fixed priority, M0 wins.
- Grant is registered. A request seen in cycle N gives gnt_o and s_cyc_o in cycle N+1. The minimum gap between back-to-back ownerships is one IDLE cycle.
- OWNx routing (combinational from the owner):
  - s_cyc_o/s_stb_o/s_we_o/s_sel_o/s_adr_o/s_dat_o follow the owner's inputs.
  - s_ack_i goes to mx_ack_o; s_dat_i goes to mx_dat_o.
  - The non-owner sees ack=0, err=0, dat=0 and waits; it is never dropped.
- OWNx to IDLE when the owner's mx_cyc_i=0. Multiple stb/ack beats are allowed within one ownership.
- Timeout counter:
  - Clears when s_ack_i=1, owner stb=0, or in IDLE.
  - Otherwise increments while owner stb=1 and s_ack_i=0.
  - When it reaches TIMEOUT_CYCLES:
    - assert mx_err_o for one cycle;
    - force s_stb_o=0 that cycle;
    - pulse tmo_irq_o;
    - clear the counter.
  - Ack is never issued together with err.
- Simultaneous ack and timeout in the same cycle: ack wins, no err.
- Owner drops cyc while stb is pending (abort): return to IDLE next cycle, counter cleared, no ack or err generated.
- Reset mid-cycle: all outputs return to reset values immediately; the slave sees s_cyc_o fall asynchronously.

Optional Feature:
- Macro: PERIPH_ARB_RR_EN.
- Defined: round-robin arbitration. A registered last-owner bit gives priority, on contention in IDLE, to the master not served last. The last-owner bit resets to 1, so M0 wins the first contention.
- Undefined: fixed priority, M0 over M1; the last-owner flop is not built.

Decomposition:
- Package periph_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2;
  - default TIMEOUT_CYCLES;
  - gnt_o encodings.
- One natural sub-module, periph_arb_timeout: counter, compare, err/irq pulse. Inputs are clk, rst_n, active, stb, ack. Outputs are tmo.
- Muxing and the FSM stay in the top module.

Test Plan:
- M0 single write adr=0x3000_0004 dat=0xA5A5_1234, slave acks 2 cycles after stb -> s_adr_o/s_dat_o match; m0_ack_o high for 1 cycle; gnt_o 01→00 after cyc drops; m1 outputs stay 0.
- M0 and M1 assert cyc in the same cycle:
  - without RR: M0 granted first, M1 granted one IDLE cycle after M0 releases;
  - with PERIPH_ARB_RR_EN, second contention: M1 granted first.
- M1 holds cyc across a read (slave returns 0x0000_00FF) then a write while M0 requests -> M0 waits the whole time; M1 transfers unbroken; M0 granted only after m1_cyc_i falls.
- Slave never acks, TIMEOUT_CYCLES=8 -> m0_err_o and tmo_irq_o pulse exactly 8 cycles after stb rises; s_stb_o low that cycle; m0_ack_o never set.
- Ack arrives on exactly cycle 8 with TIMEOUT_CYCLES=8 -> ack delivered; no err; no irq.
- wb_rst_ni pulled low while OWN1 with stb pending -> gnt_o=00 and s_cyc_o=0 without waiting for a clock edge; after release, a new M0 request is granted normally.
